// File: rtl/ps2_keyboard_receiver.sv
// PS/2 keyboard receiver: resync + deglitch the keyboard clock, frame 11-bit packets, fold E0/F0 prefixes into flags.
// Latency: keyValid/parityErr/frameErr pulse one clk after the strobe that samples the stop bit.
// Backpressure: none; every event is a single-cycle pulse and keyCodeOut/keyRelease/keyExtended hold until the next keyValid.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   clkKeyboard, data   raw PS/2 clock and data lines (asynchronous, idle high)
//   keyCodeOut          last reported scan code
//   keyValid            new event on keyCodeOut/keyRelease/keyExtended
//   keyRelease          event was preceded by F0 (break)
//   keyExtended         event was preceded by E0 (extended)
//   parityErr           odd parity check failed
//   frameErr            stop bit was 0, or a frame stalled past TIMEOUT_CYCLES
module ps2_keyboard_receiver #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int DECODE_PREFIX  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clkKeyboard,
    input  logic       data,
    output logic [7:0] keyCodeOut,
    output logic       keyValid,
    output logic       keyRelease,
    output logic       keyExtended,
    output logic       parityErr,
    output logic       frameErr
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t                 state, stateNext;
    logic [SYNC_STAGES-1:0] clkSyncSh, dataSyncSh;
    logic                   clkSync, dataSync;
    logic [FILTER_LEN-1:0]  filtSh;
    logic                   filtClk, filtClkNext, strobe;
    logic [TO_W-1:0]        toCnt;
    logic [2:0]             bitCnt;
    logic [7:0]             shiftReg;
    logic                   parityBit;
    logic                   relFlag, extFlag;
    logic                   timeoutHit, evShift, evParity, evAccept, evParErr, evStopErr;

    assign clkSync  = clkSyncSh[SYNC_STAGES-1];
    assign dataSync = dataSyncSh[SYNC_STAGES-1];

    // Synchronisers and filtered clock level.
    always_ff @(posedge clk) begin
        if (rst) begin
            clkSyncSh  <= '1;
            dataSyncSh <= '1;
            filtClk    <= 1'b1;
        end else begin
            clkSyncSh  <= {clkSyncSh[SYNC_STAGES-2:0], clkKeyboard};
            dataSyncSh <= {dataSyncSh[SYNC_STAGES-2:0], data};
            filtClk    <= filtClkNext;
        end
    end

    // History of the last FILTER_LEN synced clock samples.
    generate
        if (FILTER_LEN == 1) begin : gFilt1
            always_ff @(posedge clk) begin
                if (rst) filtSh <= '1;
                else     filtSh <= clkSync;
            end
        end else begin : gFiltN
            always_ff @(posedge clk) begin
                if (rst) filtSh <= '1;
                else     filtSh <= {filtSh[FILTER_LEN-2:0], clkSync};
            end
        end
    endgenerate

    // Level only moves once the whole history agrees; anything mixed holds it.
    assign filtClkNext = (&filtSh) ? 1'b1 : ((|filtSh) ? filtClk : 1'b0);
    assign strobe      = filtClk & ~filtClkNext;
    assign timeoutHit  = (state != IDLE) && (toCnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // Timeout wins over a coincident strobe: that strobe is dropped.
    always_comb begin
        stateNext = state;
        evShift   = 1'b0;
        evParity  = 1'b0;
        evAccept  = 1'b0;
        evParErr  = 1'b0;
        evStopErr = 1'b0;
        if (timeoutHit) begin
            stateNext = IDLE;
        end else if (strobe) begin
            unique case (state)
                IDLE:   if (!dataSync) stateNext = DATA;
                DATA: begin
                    evShift = 1'b1;
                    if (bitCnt == 3'd7) stateNext = PARITY;
                end
                PARITY: begin
                    evParity  = 1'b1;
                    stateNext = STOP;
                end
                STOP: begin
                    stateNext = IDLE;
                    if (!dataSync)                        evStopErr = 1'b1;
                    else if (^{shiftReg, parityBit} != 1'b1) evParErr = 1'b1;
                    else                                  evAccept  = 1'b1;
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            toCnt       <= '0;
            bitCnt      <= '0;
            shiftReg    <= '0;
            parityBit   <= 1'b0;
            relFlag     <= 1'b0;
            extFlag     <= 1'b0;
            keyCodeOut  <= '0;
            keyValid    <= 1'b0;
            keyRelease  <= 1'b0;
            keyExtended <= 1'b0;
            parityErr   <= 1'b0;
            frameErr    <= 1'b0;
        end else begin
            keyValid  <= 1'b0;
            parityErr <= 1'b0;
            frameErr  <= 1'b0;

            if (state == IDLE || strobe || timeoutHit) toCnt <= '0;
            else                                       toCnt <= toCnt + 1'b1;

            if (state == IDLE) bitCnt <= '0;
            if (evShift) begin
                shiftReg <= {dataSync, shiftReg[7:1]};
                bitCnt   <= bitCnt + 3'd1;
            end
            if (evParity) parityBit <= dataSync;

            // Timeout keeps the prefix flags; a received-but-bad frame clears them.
            if (timeoutHit) frameErr <= 1'b1;
            if (evStopErr || evParErr) begin
                frameErr  <= evStopErr;
                parityErr <= evParErr;
                relFlag   <= 1'b0;
                extFlag   <= 1'b0;
            end

            if (evAccept) begin
                if (DECODE_PREFIX != 0 && shiftReg == 8'hF0) begin
                    relFlag <= 1'b1;
                end else if (DECODE_PREFIX != 0 && shiftReg == 8'hE0) begin
                    extFlag <= 1'b1;
                end else begin
                    keyValid    <= 1'b1;
                    keyCodeOut  <= shiftReg;
                    keyRelease  <= relFlag;
                    keyExtended <= extFlag;
                    relFlag     <= 1'b0;
                    extFlag     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Bench for ps2_keyboard_receiver: directed PS/2 frames, an event-queue model of the
// protocol rules, and a per-cycle compare of pulses and held outputs against that model.
module tb_ps2_keyboard_receiver;

    localparam int TO_CYC = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       kbClk = 1'b1;
    logic       ps2Data = 1'b1;
    logic [7:0] keyCodeOut;
    logic       keyValid, keyRelease, keyExtended, parityErr, frameErr;

    ps2_keyboard_receiver #(
        .SYNC_STAGES   (2),
        .FILTER_LEN    (4),
        .TIMEOUT_CYCLES(TO_CYC),
        .DECODE_PREFIX (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clkKeyboard(kbClk),
        .data       (ps2Data),
        .keyCodeOut (keyCodeOut),
        .keyValid   (keyValid),
        .keyRelease (keyRelease),
        .keyExtended(keyExtended),
        .parityErr  (parityErr),
        .frameErr   (frameErr)
    );

    always #5 clk = ~clk;

    // Event kinds: 0 = key event, 1 = parity error, 2 = frame error.
    typedef struct {
        int         kind;
        logic [7:0] code;
        logic       rel;
        logic       ext;
    } ev_t;

    ev_t        evQ[$];
    logic       mRel = 1'b0, mExt = 1'b0;
    logic [7:0] heldCode = 8'h00;
    logic       heldRel = 1'b0, heldExt = 1'b0;
    int         nChecks = 0, nFail = 0;
    int         vldCnt = 0, perrCnt = 0, ferrCnt = 0;
    int         cycleCnt = 0, lastFall = 0, lastFerr = 0;

    always @(posedge clk) cycleCnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Protocol model: what a complete frame must produce.
    task automatic expectFrame(input logic [7:0] b, input logic par, input logic stop);
        ev_t e;
        e.code = b; e.rel = 1'b0; e.ext = 1'b0;
        if (!stop) begin
            e.kind = 2; evQ.push_back(e); mRel = 1'b0; mExt = 1'b0;
        end else if ((($countones(b) + int'(par)) % 2) != 1) begin
            e.kind = 1; evQ.push_back(e); mRel = 1'b0; mExt = 1'b0;
        end else if (b == 8'hF0) begin
            mRel = 1'b1;
        end else if (b == 8'hE0) begin
            mExt = 1'b1;
        end else begin
            e.kind = 0; e.rel = mRel; e.ext = mExt; evQ.push_back(e);
            mRel = 1'b0; mExt = 1'b0;
        end
    endtask

    task automatic sendBits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2Data = bits[i];
            tick(10);
            kbClk = 1'b0;
            lastFall = cycleCnt;
            tick(20);
            kbClk = 1'b1;
            tick(10);
        end
        ps2Data = 1'b1;
        tick(30);
    endtask

    task automatic sendFrame(input logic [7:0] b, input logic par, input logic stop);
        expectFrame(b, par, stop);
        sendBits({stop, par, b, 1'b0}, 11);
    endtask

    function automatic logic oddPar(input logic [7:0] b);
        return ~^b;
    endfunction

    task automatic drain(input string name);
        int k = 0;
        while (evQ.size() != 0 && k < 500) begin
            tick(1);
            k++;
        end
        check(name, 32'(evQ.size()), 32'd0);
    endtask

    // Compare process: every pulse must match the next model event; held outputs every cycle.
    always @(negedge clk) begin
        ev_t e;
        int  actKind;
        if (rst) begin
            heldCode = 8'h00; heldRel = 1'b0; heldExt = 1'b0;
            evQ.delete();
        end else begin
            if (keyValid || parityErr || frameErr) begin
                if (keyValid)  vldCnt++;
                if (parityErr) perrCnt++;
                if (frameErr) begin ferrCnt++; lastFerr = cycleCnt; end
                actKind = keyValid ? 0 : (parityErr ? 1 : 2);
                check("pulse_onehot", 32'(keyValid) + 32'(parityErr) + 32'(frameErr), 32'd1);
                if (evQ.size() == 0) begin
                    nChecks++;
                    nFail++;
                    $display("FAIL unexpected_event: got kind %0d, expected no event", actKind);
                end else begin
                    e = evQ.pop_front();
                    check("event_kind", 32'(actKind), 32'(e.kind));
                    if (e.kind == 0) begin
                        heldCode = e.code; heldRel = e.rel; heldExt = e.ext;
                    end
                end
            end
            check("held_code", 32'(keyCodeOut), 32'(heldCode));
            check("held_flags", 32'({keyRelease, keyExtended}), 32'({heldRel, heldExt}));
        end
    end

    int v0, p0, f0;

    initial begin
        tick(5);
        rst = 1'b0;
        tick(1);
        check("rst_code", 32'(keyCodeOut), 32'h00);
        check("rst_valid", 32'(keyValid), 32'd0);
        check("rst_flags", 32'({keyRelease, keyExtended}), 32'd0);
        check("rst_errs", 32'({parityErr, frameErr}), 32'd0);
        tick(20);

        // Plain make code, hand-computed bits.
        v0 = vldCnt;
        expectFrame(8'h1A, 1'b0, 1'b1);
        sendBits(11'b1_0_00011010_0, 11);
        drain("drain_1a");
        check("make_1a_count", 32'(vldCnt - v0), 32'd1);
        check("make_1a_code", 32'(keyCodeOut), 32'h1A);
        check("make_1a_flags", 32'({keyRelease, keyExtended}), 32'b00);

        // Break: F0 alone gives nothing, then 1C carries release.
        v0 = vldCnt;
        sendFrame(8'hF0, 1'b1, 1'b1);
        check("f0_no_pulse", 32'(vldCnt - v0), 32'd0);
        sendFrame(8'h1C, 1'b0, 1'b1);
        drain("drain_brk");
        check("brk_count", 32'(vldCnt - v0), 32'd1);
        check("brk_code", 32'(keyCodeOut), 32'h1C);
        check("brk_flags", 32'({keyRelease, keyExtended}), 32'b10);

        // Extended break, then flags clear on the next plain key.
        v0 = vldCnt;
        sendFrame(8'hE0, 1'b0, 1'b1);
        sendFrame(8'hF0, 1'b1, 1'b1);
        sendFrame(8'h74, 1'b1, 1'b1);
        drain("drain_ext");
        check("ext_count", 32'(vldCnt - v0), 32'd1);
        check("ext_code", 32'(keyCodeOut), 32'h74);
        check("ext_flags", 32'({keyRelease, keyExtended}), 32'b11);
        sendFrame(8'h1C, 1'b0, 1'b1);
        drain("drain_after_ext");
        check("after_ext_flags", 32'({keyRelease, keyExtended}), 32'b00);

        // Parity error holds the previous code; stop-bit error beats parity error.
        sendFrame(8'h29, oddPar(8'h29), 1'b1);
        v0 = vldCnt; p0 = perrCnt; f0 = ferrCnt;
        sendFrame(8'h1C, 1'b1, 1'b1);
        drain("drain_perr");
        check("perr_count", 32'(perrCnt - p0), 32'd1);
        check("perr_no_valid", 32'(vldCnt - v0), 32'd0);
        check("perr_code_held", 32'(keyCodeOut), 32'h29);
        p0 = perrCnt;
        sendFrame(8'h1C, 1'b0, 1'b0);
        sendFrame(8'h1C, 1'b1, 1'b0);
        drain("drain_ferr");
        check("stop_ferr_count", 32'(ferrCnt - f0), 32'd2);
        check("stop_no_perr", 32'(perrCnt - p0), 32'd0);

        // A bad frame clears a pending F0.
        sendFrame(8'hF0, 1'b1, 1'b1);
        sendFrame(8'h1C, 1'b1, 1'b1);
        sendFrame(8'h1C, 1'b0, 1'b1);
        drain("drain_clr");
        check("err_clears_flag", 32'({keyRelease, keyExtended}), 32'b00);

        // Timeout: partial frame aborts with frameErr, pending F0 survives it.
        sendFrame(8'hF0, 1'b1, 1'b1);
        f0 = ferrCnt;
        begin
            ev_t e;
            e.kind = 2; e.code = 8'h00; e.rel = 1'b0; e.ext = 1'b0;
            evQ.push_back(e);
        end
        sendBits(11'b000_0000_1101_0, 5);
        drain("drain_timeout");
        check("to_ferr_count", 32'(ferrCnt - f0), 32'd1);
        check("to_delay_window",
              32'((lastFerr - lastFall >= TO_CYC) && (lastFerr - lastFall <= TO_CYC + 15)), 32'd1);
        sendFrame(8'h1C, 1'b0, 1'b1);
        drain("drain_after_to");
        check("after_to_code", 32'(keyCodeOut), 32'h1C);
        check("after_to_flags", 32'({keyRelease, keyExtended}), 32'b10);

        // Two-cycle low glitch with data low: must not start a frame.
        v0 = vldCnt; f0 = ferrCnt; p0 = perrCnt;
        ps2Data = 1'b0;
        tick(5);
        kbClk = 1'b0;
        tick(2);
        kbClk = 1'b1;
        tick(5);
        ps2Data = 1'b1;
        tick(TO_CYC + 50);
        check("glitch_no_events", 32'((vldCnt - v0) + (ferrCnt - f0) + (perrCnt - p0)), 32'd0);
        sendFrame(8'h1A, 1'b0, 1'b1);
        drain("drain_glitch");
        check("glitch_next_code", 32'(keyCodeOut), 32'h1A);

        // Reset mid-DATA: outputs clear, no pulse for the partial frame, next frame clean.
        v0 = vldCnt; f0 = ferrCnt; p0 = perrCnt;
        sendBits(11'b000_0000_0101_0, 4);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("midrst_code", 32'(keyCodeOut), 32'h00);
        check("midrst_pulses", 32'({keyValid, parityErr, frameErr}), 32'd0);
        mRel = 1'b0; mExt = 1'b0;
        tick(TO_CYC + 50);
        check("midrst_no_events", 32'((vldCnt - v0) + (ferrCnt - f0) + (perrCnt - p0)), 32'd0);
        sendFrame(8'h1C, 1'b0, 1'b1);
        drain("drain_midrst");
        check("midrst_next_code", 32'(keyCodeOut), 32'h1C);
        check("midrst_next_flags", 32'({keyRelease, keyExtended}), 32'b00);

        tick(20);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
